// File: rtl/uart_rx_fsm_if.sv
// Receiver-side signal bundle: serial line and frame configuration towards the
// receiver, received byte and status pulses back from it.
interface uart_rx_fsm_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (
    output RX_IN,
    output PRESCALE,
    output PAR_EN,
    output PAR_TYP,
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_ERR,
    input  STP_ERR
  );

  modport slave (
    input  RX_IN,
    input  PRESCALE,
    input  PAR_EN,
    input  PAR_TYP,
    output P_DATA,
    output DATA_VALID,
    output PAR_ERR,
    output STP_ERR
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled start/data/parity/stop framing with a three-sample
// majority vote per bit; each good byte is delivered with a one-cycle DATA_VALID pulse.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         CLK,
  input  logic         RST,
  uart_rx_fsm_if.slave rx_if
);

  localparam int            BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_e                state_q;
  logic [5:0]            edge_cnt_q;
  logic [5:0]            edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q;
  logic [2:0]            samp_q;
  logic [5:0]            prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_fail_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  logic [5:0]            prescale_eff_s;
  logic [5:0]            half_s;
  logic [5:0]            last_edge_s;
  logic                  edge_wrap_s;
  logic                  eval_s;
  logic                  bit_val_s;

  // Bit-period timing derived from the prescale latched at start detect
  always_comb begin
    prescale_eff_s = (rx_if.PRESCALE == 6'd0) ? 6'd8 : rx_if.PRESCALE;
    half_s         = prescale_q >> 1;
    last_edge_s    = prescale_q - 6'd1;
    edge_wrap_s    = (edge_cnt_q == last_edge_s);
    edge_cnt_d     = edge_wrap_s ? 6'd0 : (edge_cnt_q + 6'd1);
    eval_s         = (edge_cnt_q == (half_s + 6'd2));
    bit_val_s      = majority3(samp_q);
  end

  // Frame FSM with sampling, shift register and registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      edge_cnt_q   <= 6'd0;
      bit_cnt_q    <= '0;
      samp_q       <= 3'b000;
      prescale_q   <= 6'd8;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_fail_q   <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;

      if (state_q != IDLE) begin
        edge_cnt_q <= edge_cnt_d;
        if (edge_cnt_q == (half_s - 6'd1)) begin
          samp_q[0] <= rx_if.RX_IN;
        end else if (edge_cnt_q == half_s) begin
          samp_q[1] <= rx_if.RX_IN;
        end else if (edge_cnt_q == (half_s + 6'd1)) begin
          samp_q[2] <= rx_if.RX_IN;
        end
      end

      case (state_q)
        IDLE: begin
          edge_cnt_q <= 6'd0;
          bit_cnt_q  <= '0;
          // The detect cycle itself is edge 0 of the start bit
          if (!rx_if.RX_IN) begin
            state_q    <= START;
            edge_cnt_q <= 6'd1;
            prescale_q <= prescale_eff_s;
            par_en_q   <= rx_if.PAR_EN;
            par_typ_q  <= rx_if.PAR_TYP;
            par_fail_q <= 1'b0;
          end
        end

        START: begin
          if (eval_s && bit_val_s) begin
            state_q    <= IDLE;
            edge_cnt_q <= 6'd0;
          end else if (edge_wrap_s) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end

        DATA: begin
          if (eval_s) begin
            shift_q <= {bit_val_s, shift_q[DATA_WIDTH-1:1]};
          end
          if (edge_wrap_s) begin
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1'b1);
            end
          end
        end

        PARITY: begin
          if (eval_s) begin
            par_fail_q <= (bit_val_s != parity_of(shift_q, par_typ_q));
          end
          if (edge_wrap_s) begin
            state_q <= STOP;
          end
        end

        // Finish at mid-stop so a following start edge is not missed; the wrap
        // term only matters for illegal prescales whose evaluation point never comes
        STOP: begin
          if (eval_s || edge_wrap_s) begin
            state_q    <= IDLE;
            edge_cnt_q <= 6'd0;
            stp_err_q  <= ~bit_val_s;
            par_err_q  <= par_fail_q;
            if (bit_val_s && !par_fail_q) begin
              p_data_q     <= shift_q;
              data_valid_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q    <= IDLE;
          edge_cnt_q <= 6'd0;
        end
      endcase
    end
  end

  assign rx_if.P_DATA     = p_data_q;
  assign rx_if.DATA_VALID = data_valid_q;
  assign rx_if.PAR_ERR    = par_err_q;
  assign rx_if.STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: builds per-cycle serial waveforms, plays them and
// checks pulse cycles (relative to the start-detect cycle), data and error flags.
module tb_uart_rx_fsm;
  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST;
  uart_rx_fsm_if #(.DATA_WIDTH(DW)) rx_if ();

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .rx_if(rx_if)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic          wave[$];
  int            dv_cyc[$];
  logic [DW-1:0] dv_dat[$];
  int            pe_cyc[$];
  int            se_cyc[$];
  int            dbl;
  logic [DW+2:0] post_rst;

  task automatic add_idle(input int n, input logic v);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask

  task automatic add_frame(input logic [DW-1:0] d, input int p, input bit par_en,
                           input logic par_bit, input logic stop_bit, input bit corrupt);
    logic bits[$];
    logic v;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (par_en) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    foreach (bits[b]) begin
      for (int c = 0; c < p; c++) begin
        v = bits[b];
        if (corrupt && c == p / 2 - 1) v = ~v;
        wave.push_back(v);
      end
    end
  endtask

  task automatic set_cfg(input logic [5:0] p, input logic pe, input logic pt);
    rx_if.PRESCALE = p;
    rx_if.PAR_EN   = pe;
    rx_if.PAR_TYP  = pt;
  endtask

  // Cycle k of the run is the cycle in which the FSM sees wave[k].
  task automatic run_wave(input int tail, input int rst_at, input int flip_at);
    logic pdv, ppe, pse;
    int   n;
    dv_cyc = {}; dv_dat = {}; pe_cyc = {}; se_cyc = {};
    dbl = 0; pdv = 1'b0; ppe = 1'b0; pse = 1'b0;
    post_rst = '1;
    n = wave.size();
    for (int k = 0; k < n + tail; k++) begin
      @(negedge CLK);
      if (rx_if.DATA_VALID === 1'b1) begin
        dv_cyc.push_back(k);
        dv_dat.push_back(rx_if.P_DATA);
      end
      if (rx_if.PAR_ERR === 1'b1) pe_cyc.push_back(k);
      if (rx_if.STP_ERR === 1'b1) se_cyc.push_back(k);
      if ((rx_if.DATA_VALID && pdv) || (rx_if.PAR_ERR && ppe) || (rx_if.STP_ERR && pse)) dbl++;
      pdv = rx_if.DATA_VALID; ppe = rx_if.PAR_ERR; pse = rx_if.STP_ERR;
      if (rst_at >= 0 && k == rst_at + 1)
        post_rst = {rx_if.P_DATA, rx_if.DATA_VALID, rx_if.PAR_ERR, rx_if.STP_ERR};
      if (rst_at >= 0 && k == rst_at) RST = 1'b1;
      if (rst_at >= 0 && k == rst_at + 2) RST = 1'b0;
      if (k == flip_at) set_cfg(6'd16, 1'b1, 1'b1);
      if (rst_at >= 0 && k >= rst_at) rx_if.RX_IN = 1'b1;
      else rx_if.RX_IN = (k < n) ? wave[k] : 1'b1;
    end
    wave = {};
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    rx_if.RX_IN = 1'b1;
    set_cfg(6'd8, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({rx_if.P_DATA, rx_if.DATA_VALID, rx_if.PAR_ERR, rx_if.STP_ERR} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {rx_if.P_DATA, rx_if.DATA_VALID, rx_if.PAR_ERR, rx_if.STP_ERR});
    end
  endtask

  task automatic test_basic();
    set_cfg(6'd8, 1'b0, 1'b0);
    add_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    run_wave(12, -1, 4);  // config changed mid-frame must be ignored
    checks++;
    if (dv_cyc.size() != 1) begin errors++; $display("FAIL basic_dv_count: got %0d expected 1", dv_cyc.size()); end
    checks++;
    if (first_of(dv_cyc) != 79) begin errors++; $display("FAIL basic_dv_cycle: got %0d expected 79", first_of(dv_cyc)); end
    checks++;
    if (rx_if.P_DATA !== 8'hA5) begin errors++; $display("FAIL basic_pdata: got %h expected a5", rx_if.P_DATA); end
    checks++;
    if (pe_cyc.size() + se_cyc.size() != 0 || dbl != 0) begin
      errors++; $display("FAIL basic_err_pulses: got pe=%0d se=%0d dbl=%0d expected 0", pe_cyc.size(), se_cyc.size(), dbl);
    end
  endtask

  task automatic test_parity();
    set_cfg(6'd16, 1'b1, 1'b0);
    add_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
    run_wave(12, -1, -1);
    checks++;
    if (dv_cyc.size() != 1 || first_of(dv_cyc) != 171) begin
      errors++; $display("FAIL par_good_dv: got n=%0d cyc=%0d expected n=1 cyc=171", dv_cyc.size(), first_of(dv_cyc));
    end
    checks++;
    if (rx_if.P_DATA !== 8'h3C || pe_cyc.size() != 0) begin
      errors++; $display("FAIL par_good_data: got %h pe=%0d expected 3c pe=0", rx_if.P_DATA, pe_cyc.size());
    end
    set_cfg(6'd16, 1'b1, 1'b0);
    add_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0);
    run_wave(12, -1, -1);
    checks++;
    if (pe_cyc.size() != 1 || first_of(pe_cyc) != 171) begin
      errors++; $display("FAIL par_bad_pe: got n=%0d cyc=%0d expected n=1 cyc=171", pe_cyc.size(), first_of(pe_cyc));
    end
    checks++;
    if (dv_cyc.size() != 0 || se_cyc.size() != 0 || rx_if.P_DATA !== 8'h3C) begin
      errors++; $display("FAIL par_bad_quiet: got dv=%0d se=%0d pdata=%h expected 0 0 3c", dv_cyc.size(), se_cyc.size(), rx_if.P_DATA);
    end
    set_cfg(6'd16, 1'b1, 1'b1);
    add_frame(8'h07, 16, 1'b1, 1'b0, 1'b1, 1'b0);  // odd parity of three ones is 0
    run_wave(12, -1, -1);
    checks++;
    if (dv_cyc.size() != 1 || first_of(dv_cyc) != 171 || rx_if.P_DATA !== 8'h07 || pe_cyc.size() != 0) begin
      errors++; $display("FAIL par_odd: got n=%0d cyc=%0d pdata=%h pe=%0d expected 1 171 07 0",
                         dv_cyc.size(), first_of(dv_cyc), rx_if.P_DATA, pe_cyc.size());
    end
  endtask

  task automatic test_stop_err();
    set_cfg(6'd8, 1'b0, 1'b0);
    add_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    run_wave(16, -1, -1);
    checks++;
    if (se_cyc.size() != 1 || first_of(se_cyc) != 79) begin
      errors++; $display("FAIL stop_se: got n=%0d cyc=%0d expected n=1 cyc=79", se_cyc.size(), first_of(se_cyc));
    end
    checks++;
    if (dv_cyc.size() != 0 || pe_cyc.size() != 0 || rx_if.P_DATA !== 8'h07) begin
      errors++; $display("FAIL stop_quiet: got dv=%0d pe=%0d pdata=%h expected 0 0 07", dv_cyc.size(), pe_cyc.size(), rx_if.P_DATA);
    end
    set_cfg(6'd8, 1'b1, 1'b0);
    add_frame(8'h11, 8, 1'b1, 1'b1, 1'b0, 1'b0);
    run_wave(16, -1, -1);
    checks++;
    if (first_of(pe_cyc) != 87 || first_of(se_cyc) != 87 || dv_cyc.size() != 0) begin
      errors++; $display("FAIL stop_both: got pe=%0d se=%0d dv=%0d expected 87 87 0",
                         first_of(pe_cyc), first_of(se_cyc), dv_cyc.size());
    end
    set_cfg(6'd8, 1'b0, 1'b0);
    add_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    run_wave(12, -1, -1);
    checks++;
    if (dv_cyc.size() != 1 || first_of(dv_cyc) != 79 || rx_if.P_DATA !== 8'h22) begin
      errors++; $display("FAIL stop_recover: got n=%0d cyc=%0d pdata=%h expected 1 79 22",
                         dv_cyc.size(), first_of(dv_cyc), rx_if.P_DATA);
    end
  endtask

  task automatic test_glitch();
    set_cfg(6'd16, 1'b0, 1'b0);
    add_idle(3, 1'b0);
    add_idle(8, 1'b1);
    add_frame(8'h7E, 16, 1'b0, 1'b0, 1'b1, 1'b0);  // starts at cycle 11
    run_wave(12, -1, -1);
    checks++;
    if (dv_cyc.size() != 1 || first_of(dv_cyc) != 166) begin
      errors++; $display("FAIL glitch_dv: got n=%0d cyc=%0d expected n=1 cyc=166", dv_cyc.size(), first_of(dv_cyc));
    end
    checks++;
    if (rx_if.P_DATA !== 8'h7E || pe_cyc.size() != 0 || se_cyc.size() != 0) begin
      errors++; $display("FAIL glitch_data: got %h pe=%0d se=%0d expected 7e 0 0", rx_if.P_DATA, pe_cyc.size(), se_cyc.size());
    end
  endtask

  task automatic test_majority();
    set_cfg(6'd32, 1'b0, 1'b0);
    add_frame(8'hC3, 32, 1'b0, 1'b0, 1'b1, 1'b1);
    run_wave(12, -1, -1);
    checks++;
    if (dv_cyc.size() != 1 || first_of(dv_cyc) != 307) begin
      errors++; $display("FAIL majority_dv: got n=%0d cyc=%0d expected n=1 cyc=307", dv_cyc.size(), first_of(dv_cyc));
    end
    checks++;
    if (rx_if.P_DATA !== 8'hC3 || se_cyc.size() != 0) begin
      errors++; $display("FAIL majority_data: got %h se=%0d expected c3 0", rx_if.P_DATA, se_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(6'd8, 1'b0, 1'b0);
    add_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    add_frame(8'h80, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    add_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    run_wave(20, 190, -1);
    checks++;
    if (dv_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d expected 2", dv_cyc.size());
    end else begin
      checks++;
      if (dv_cyc[0] != 79 || dv_dat[0] !== 8'h01) begin
        errors++; $display("FAIL b2b_first: got cyc=%0d data=%h expected 79 01", dv_cyc[0], dv_dat[0]);
      end
      checks++;
      if (dv_cyc[1] != 159 || dv_dat[1] !== 8'h80) begin
        errors++; $display("FAIL b2b_second: got cyc=%0d data=%h expected 159 80", dv_cyc[1], dv_dat[1]);
      end
    end
    checks++;
    if (post_rst !== 11'd0) begin
      errors++; $display("FAIL b2b_post_reset: got %b expected all zero", post_rst);
    end
    checks++;
    if (rx_if.P_DATA !== 8'h00 || pe_cyc.size() != 0 || se_cyc.size() != 0 || dbl != 0) begin
      errors++; $display("FAIL b2b_aborted: got pdata=%h pe=%0d se=%0d dbl=%0d expected 00 0 0 0",
                         rx_if.P_DATA, pe_cyc.size(), se_cyc.size(), dbl);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_glitch();
    test_majority();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Serial receiver that pairs with the UART transmitter. It consumes the TX_OUT-style serial line (start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit).
- Oversamples the line by a runtime PRESCALE and majority-votes three mid-bit samples per bit.
- Checks the start bit, parity and stop bit, then delivers the received byte to the downstream register/FIFO stage as a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- CLK  input  1  system clock (oversampling clock).
- RST  input  1  synchronous reset, active-high.
- RX_IN  input  1  serial line, idle high. Already synchronized to CLK by an external 2-flop synchronizer.
- PRESCALE  input  6  oversampling ratio. Legal values are 8, 16 and 32.
- PAR_EN  input  1  1 = frame contains a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last correctly received byte.
- DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
- PAR_ERR  output  1  one-cycle pulse when a frame has a parity mismatch.
- STP_ERR  output  1  one-cycle pulse when a frame has a stop bit sampled 0.

Behaviour:
- Reset: on a CLK edge with RST=1:
  - state goes to IDLE; edge_cnt, bit_cnt and sample registers clear to 0;
  - P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0.
  - RST mid-frame aborts the frame with no output pulse. Reset has priority over all other events.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - The cycle in which RX_IN=0 is seen counts as edge_cnt=0 of the start bit; the next state is START.
  - PRESCALE, PAR_EN and PAR_TYP are latched in that cycle and held for the whole frame. Input changes mid-frame are ignored.
- edge_cnt runs 0..P-1 in every bit period (P = latched PRESCALE), wraps to 0 at P-1, and bit_cnt advances on the wrap.
- Sampling:
  - RX_IN is registered at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of those three samples, evaluated at edge_cnt = P/2+2.
- START:
  - At the evaluation point, if the majority is 1 the start is a glitch: go to IDLE with no output.
  - Otherwise stay in START until edge_cnt=P-1, then go to DATA.
- DATA:
  - Each evaluated bit shifts into an internal shift register, LSB first.
  - After bit DATA_WIDTH-1, at edge_cnt=P-1, go to PARITY if PAR_EN=1, else to STOP.
- PARITY:
  - Expected parity is XOR of the data bits, inverted when PAR_TYP=1.
  - A mismatch sets an internal par_fail flag.
  - At edge_cnt=P-1, go to STOP.
- STOP: at the evaluation point (edge_cnt=P/2+2), do all of the following in the same cycle and return to IDLE. The rest of the stop period is not waited out, so back-to-back frames are accepted.
  - If the majority is 0, pulse STP_ERR.
  - If par_fail is set, pulse PAR_ERR.
  - If neither error occurred, load P_DATA from the shift register and pulse DATA_VALID.
- Outputs are registered and go high the cycle after the evaluation cycle.
  - DATA_VALID latency, counted from the start-detect cycle (cycle 0): 9P+P/2+3 cycles without parity, 10P+P/2+3 with parity.
  - An erroneous frame never asserts DATA_VALID, and P_DATA keeps its previous value.
  - Both PAR_ERR and STP_ERR may pulse in the same cycle.
- Illegal PRESCALE values give undefined framing, but the FSM must still return to IDLE: every bit period ends at edge_cnt=P-1, and P=0 is treated as 8.
- If RX_IN is low when RST deasserts, it is treated as a start edge. The FSM resynchronises on the next idle-high gap.
- DATA_VALID, PAR_ERR and STP_ERR are never high for more than one consecutive cycle.

Test Plan:
- Reset, then PRESCALE=8, PAR_EN=0, send 0xA5 -> DATA_VALID pulses once at cycle 79 after the start edge; P_DATA=0xA5; PAR_ERR=STP_ERR=0.
- PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> DATA_VALID at cycle 171; P_DATA=0x3C. Repeat with a wrong parity bit -> PAR_ERR pulse at cycle 171, no DATA_VALID, P_DATA stays 0x3C.
- PRESCALE=8, stop bit driven 0, data 0x11 -> STP_ERR pulse at cycle 79, no DATA_VALID. Next frame 0x22 with a good stop bit is received correctly.
- RX_IN low for 3 cycles then high (glitch), PRESCALE=16 -> FSM back in IDLE by cycle 11, no output pulses. A following valid frame 0x7E is received.
- One sample corrupted per bit (e.g. at edge_cnt=P/2-1), PRESCALE=32, data 0xC3 -> majority vote recovers it; P_DATA=0xC3, DATA_VALID asserted.
- Back-to-back frames 0x01, 0x80 with no idle gap, then RST asserted mid-way through a third frame -> two DATA_VALID pulses with the correct bytes. After RST, all outputs are 0 and no pulse appears for the aborted frame.
